// File: rtl/edge_filter_nch.sv
// Multi-channel input conditioner: per-channel synchroniser, stability filter
// and registered single-cycle rise/fall strobes.
module edge_filter_nch #(
  parameter int            CH          = 4,
  parameter int            SYNC_STAGES = 2,
  parameter int            FILT_CNT    = 3,
  parameter logic [CH-1:0] RST_LEVEL   = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_edge
);

  localparam int               CNT_W    = $clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  generate
    if (CH < 1 || SYNC_STAGES < 2 || FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_param
      $error("edge_filter_nch: illegal parameters CH=%0d SYNC_STAGES=%0d FILT_CNT=%0d",
             CH, SYNC_STAGES, FILT_CNT);
    end
  endgenerate

  logic [CH-1:0] edge_next;
  logic          any_edge_reg;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   level_reg;
    logic                   level_next;
    logic                   rise_reg;
    logic                   rise_next;
    logic                   fall_reg;
    logic                   fall_next;
    logic                   s;

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_reg  <= {SYNC_STAGES{RST_LEVEL[gi]}};
        cnt_reg   <= '0;
        level_reg <= RST_LEVEL[gi];
        rise_reg  <= 1'b0;
        fall_reg  <= 1'b0;
      end else begin
        sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din[gi]};
        cnt_reg   <= cnt_next;
        level_reg <= level_next;
        rise_reg  <= rise_next;
        fall_reg  <= fall_next;
      end
    end

    // Count consecutive samples disagreeing with level; any agreeing sample
    // or a disabled cycle restarts qualification from zero.
    always_comb begin
      cnt_next   = '0;
      level_next = level_reg;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      if (en && (s != level_reg)) begin
        if (cnt_reg == CNT_LAST) begin
          level_next = s;
          rise_next  = s;
          fall_next  = ~s;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    end

    assign edge_next[gi] = rise_next | fall_next;
    assign level[gi]     = level_reg;
    assign rise[gi]      = rise_reg;
    assign fall[gi]      = fall_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_edge_reg <= 1'b0;
    end else begin
      any_edge_reg <= |edge_next;
    end
  end

  assign any_edge = any_edge_reg;

endmodule
